// File: rtl/lcd_pkg.sv
// Shared definitions for the 8-bit parallel LCD bus: display geometry,
// instruction bit positions and the responder state encoding.
`timescale 1ns/1ps
package lcd_pkg;

  localparam int LCD_COLS = 16;
  localparam int LCD_ROWS = 2;
  localparam int ADDR_W   = 5;
  localparam int CELLS    = LCD_COLS * LCD_ROWS;
  localparam int BUS_W    = 8;

  localparam int CLEAR_BIT = 0;
  localparam int HOME_BIT  = 1;
  localparam int ENTRY_BIT = 2;
  localparam int DDRAM_BIT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DDRAM
  } instr_op_t;

  // Highest set bit selects the instruction; bits 6..3 are accepted but inert.
  function automatic instr_op_t decode_instr(input logic [BUS_W-1:0] d);
    if (d[DDRAM_BIT])                      return OP_DDRAM;
    else if (|d[DDRAM_BIT-1:ENTRY_BIT+1])  return OP_NOP;
    else if (d[ENTRY_BIT])                 return OP_ENTRY;
    else if (d[HOME_BIT])                  return OP_HOME;
    else if (d[CLEAR_BIT])                 return OP_CLEAR;
    else                                   return OP_NOP;
  endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Brings the asynchronous LCD bus into the clk domain and emits a one-cycle
// strobe on each enable falling edge that followed a wide-enough high pulse.
`timescale 1ns/1ps
module lcd_strobe_sync
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_EN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BUS_W-1:0] lcd_data,
  input  logic             lcd_sel,
  input  logic             lcd_en,
  output logic             strobe,
  output logic [BUS_W-1:0] data,
  output logic             sel
);

  localparam int LINE_W = BUS_W + 2;
  localparam int CNT_W  = $clog2(MIN_EN_CYCLES + 1);

  logic [SYNC_STAGES-1:0][LINE_W-1:0] bus_sync;
  logic [LINE_W-1:0]                  bus_s;
  logic                               en_s;
  logic                               en_prev;
  logic [CNT_W-1:0]                   width_cnt;
  logic                               width_ok;

  // All three lines share one chain so data and select stay aligned with enable.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_sync <= '0;
      en_prev  <= 1'b0;
    end else begin
      bus_sync <= {bus_sync[SYNC_STAGES-2:0], {lcd_en, lcd_sel, lcd_data}};
      en_prev  <= en_s;
    end
  end

  assign bus_s = bus_sync[SYNC_STAGES-1];
  assign en_s  = bus_s[LINE_W-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width_cnt <= '0;
    end else if (!en_s) begin
      width_cnt <= '0;
    end else if (!width_ok) begin
      width_cnt <= width_cnt + CNT_W'(1);
    end
  end

  assign width_ok = (width_cnt == CNT_W'(MIN_EN_CYCLES));

  // The counter still holds the high-pulse width in the cycle enable drops.
  assign strobe = en_prev && !en_s && width_ok;
  assign sel    = bus_s[BUS_W];
  assign data   = bus_s[BUS_W-1:0];

endmodule

// File: rtl/lcd_bus_responder.sv
// LCD-side responder: turns captured bus transfers into a 2x16 display-RAM
// write stream with valid/ready handshake and emulated controller busy time.
`timescale 1ns/1ps
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter int         MIN_EN_CYCLES = 3,
  parameter int         BUSY_CYCLES   = 480,
  parameter logic [7:0] CLEAR_FILL    = 8'h20
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [BUS_W-1:0]  lcd_data_i,
  input  logic              lcd_reset_i,
  input  logic              lcd_enable_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [BUS_W-1:0]  wr_data_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic [ADDR_W-1:0] cursor_o,
  output logic [15:0]       xfer_count_o
);

  localparam int BCNT_W = $clog2(BUSY_CYCLES + 1);
  localparam logic [BCNT_W-1:0] BUSY_LOAD = BCNT_W'(BUSY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  logic             strobe;
  logic [BUS_W-1:0] s_data;
  logic             s_sel;

  state_t              state_q, state_d;
  instr_op_t           op;
  logic                accept, drop, hs, busy_done, clear_last;
  logic [BCNT_W-1:0]   busy_cnt_q;
  logic [ADDR_W-1:0]   cursor_q;
  logic                incr_q;
  logic                wr_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [BUS_W-1:0]    wr_data_q;
  logic                overrun_q;
  logic [15:0]         xfer_q;

  lcd_strobe_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .MIN_EN_CYCLES(MIN_EN_CYCLES)
  ) u_sync (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .lcd_data(lcd_data_i),
    .lcd_sel (lcd_reset_i),
    .lcd_en  (lcd_enable_i),
    .strobe  (strobe),
    .data    (s_data),
    .sel     (s_sel)
  );

  // A strobe arriving while a write is still visible is dropped, even if that
  // write completes its handshake in the same cycle.
  assign op         = decode_instr(s_data);
  assign accept     = strobe && (state_q == IDLE) && !wr_valid_q;
  assign drop       = strobe && !accept;
  assign hs         = wr_valid_q && wr_ready_i;
  assign busy_done  = (busy_cnt_q == '0);
  assign clear_last = hs && (wr_addr_q == LAST_CELL);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = (!s_sel && op == OP_CLEAR) ? CLEAR : BUSY;
      BUSY:  if (busy_done && !wr_valid_q) state_d = IDLE;
      CLEAR: if (clear_last) state_d = BUSY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE) || wr_valid_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_cnt_q <= '0;
      cursor_q   <= '0;
      incr_q     <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      overrun_q  <= 1'b0;
      xfer_q     <= '0;
    end else begin
      overrun_q <= drop;
      if (accept) begin
        busy_cnt_q <= BUSY_LOAD;
        if (xfer_q != 16'hFFFF) xfer_q <= xfer_q + 16'd1;
        if (s_sel) begin
          wr_valid_q <= 1'b1;
          wr_addr_q  <= cursor_q;
          wr_data_q  <= s_data;
          cursor_q   <= incr_q ? cursor_q + ADDR_W'(1) : cursor_q - ADDR_W'(1);
        end else begin
          unique case (op)
            OP_DDRAM: cursor_q <= {s_data[6], s_data[3:0]};
            OP_ENTRY: incr_q   <= s_data[1];
            OP_HOME:  cursor_q <= '0;
            OP_CLEAR: begin
              wr_valid_q <= 1'b1;
              wr_addr_q  <= '0;
              wr_data_q  <= CLEAR_FILL;
            end
            default: ;
          endcase
        end
      end else if (state_q == CLEAR) begin
        if (clear_last) begin
          wr_valid_q <= 1'b0;
          cursor_q   <= '0;
          incr_q     <= 1'b1;
          busy_cnt_q <= BUSY_LOAD;
        end else if (hs) begin
          wr_addr_q <= wr_addr_q + ADDR_W'(1);
        end
      end else begin
        if (hs) wr_valid_q <= 1'b0;
        if (state_q == BUSY && !busy_done) busy_cnt_q <= busy_cnt_q - BCNT_W'(1);
      end
    end
  end

  assign wr_valid_o   = wr_valid_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign overrun_o    = overrun_q;
  assign cursor_o     = cursor_q;
  assign xfer_count_o = xfer_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: drives LCD bus transfers and checks
// the display write stream, cursor, counters and busy timing.
`timescale 1ns/1ps
module tb_lcd_bus_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  lcd_data = '0;
  logic        lcd_sel = 1'b0;
  logic        lcd_en = 1'b0;
  logic        rdy_fixed = 1'b1;
  logic        rdy_tog = 1'b1;
  logic        tog_en = 1'b0;
  logic        wr_ready;
  logic        wr_valid, busy, overrun;
  logic [4:0]  wr_addr, cursor;
  logic [7:0]  wr_data;
  logic [15:0] xfer_count;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;
  int ocnt  = 0;
  logic [4:0] wa_q[$];
  logic [7:0] wd_q[$];

  assign wr_ready = tog_en ? rdy_tog : rdy_fixed;

  always #5 clk = ~clk;

  lcd_bus_responder dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .lcd_data_i  (lcd_data),
    .lcd_reset_i (lcd_sel),
    .lcd_enable_i(lcd_en),
    .wr_valid_o  (wr_valid),
    .wr_ready_i  (wr_ready),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .busy_o      (busy),
    .overrun_o   (overrun),
    .cursor_o    (cursor),
    .xfer_count_o(xfer_count)
  );

  always @(posedge clk) begin
    #1 rdy_tog = ~rdy_tog;
  end

  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (wr_valid) vcnt++;
    if (overrun)  ocnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic strobe(input logic [7:0] d, input logic s, input int hi);
    @(posedge clk); #2;
    lcd_data = d;
    lcd_sel  = s;
    lcd_en   = 1'b1;
    repeat (hi) @(posedge clk);
    #2 lcd_en = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 3000 && wa_q.size() < target; i++) begin
      @(negedge clk); #1;
    end
    check("wait_wr", wa_q.size(), target);
  endtask

  task automatic busy_run(output int len);
    len = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
      len++;
    end
  endtask

  int len, base, v0, o0;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_valid",  {31'd0, wr_valid}, 32'd0);
    check("rst_busy",   {31'd0, busy},     32'd0);
    check("rst_ovr",    {31'd0, overrun},  32'd0);
    check("rst_addr",   {27'd0, wr_addr},  32'd0);
    check("rst_data",   {24'd0, wr_data},  32'd0);
    check("rst_cursor", {27'd0, cursor},   32'd0);
    check("rst_xfer",   {16'd0, xfer_count}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Character write after reset.
    strobe(8'h41, 1'b1, 4);
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    busy_run(len);
    check("busy_len", len + 1, 480);
    check("wr1_cnt",  wa_q.size(), 1);
    check("wr1_addr", wa_q[0], 5'h00);
    check("wr1_data", wd_q[0], 8'h41);
    check("wr1_vcyc", vcnt, 1);
    check("cur1",     cursor, 5'h01);
    check("xfer1",    xfer_count, 16'd1);

    // Set DDRAM then character write.
    strobe(8'hC5, 1'b0, 4);
    wait_idle();
    check("cur_ddram", cursor, 5'h15);
    strobe(8'h5A, 1'b1, 4);
    wait_idle();
    check("wr2_addr", wa_q[wa_q.size()-1], 5'h15);
    check("wr2_data", wd_q[wd_q.size()-1], 8'h5A);
    check("cur2",     cursor, 5'h16);

    // Decrement entry mode, home, write: cursor wraps to 31.
    strobe(8'h04, 1'b0, 4);
    wait_idle();
    strobe(8'h02, 1'b0, 4);
    wait_idle();
    check("cur_home", cursor, 5'h00);
    strobe(8'h33, 1'b1, 4);
    wait_idle();
    check("wr3_addr", wa_q[wa_q.size()-1], 5'h00);
    check("wr3_data", wd_q[wd_q.size()-1], 8'h33);
    check("cur_wrap", cursor, 5'h1F);
    check("xfer3",    xfer_count, 16'd6);

    // Clear display with a toggling sink.
    base = wa_q.size();
    tog_en = 1'b1;
    strobe(8'h01, 1'b0, 4);
    wait_writes(base + 32);
    busy_run(len);
    check("clr_busy_len", len, 480);
    tog_en = 1'b0;
    for (int i = 0; i < 32; i++)
      check("clr_wr", {19'd0, wa_q[base+i], wd_q[base+i]}, {19'd0, 5'(i), 8'h20});
    repeat (20) @(negedge clk);
    check("clr_count", wa_q.size(), base + 32);
    check("clr_cursor", cursor, 5'h00);
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("xfer4", xfer_count, 16'd7);

    // Strobe during BUSY is dropped; narrow strobe in IDLE is ignored.
    o0 = ocnt;
    strobe(8'h41, 1'b1, 4);
    strobe(8'h42, 1'b1, 4);
    wait_idle();
    check("ovr_pulses", ocnt - o0, 1);
    check("xfer5", xfer_count, 16'd8);
    check("wr5_addr", wa_q[wa_q.size()-1], 5'h00);
    check("wr5_data", wd_q[wd_q.size()-1], 8'h41);
    check("cur5_incr", cursor, 5'h01);
    base = wa_q.size();
    o0 = ocnt;
    strobe(8'h55, 1'b1, 2);
    repeat (12) @(negedge clk);
    check("narrow_ovr",  ocnt - o0, 0);
    check("narrow_xfer", xfer_count, 16'd8);
    check("narrow_wr",   wa_q.size(), base);
    check("narrow_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a clear.
    base = wa_q.size();
    strobe(8'h01, 1'b0, 4);
    wait_writes(base + 10);
    reset_n = 1'b0;
    #1;
    check("ar_valid",  {31'd0, wr_valid}, 32'd0);
    check("ar_busy",   {31'd0, busy},     32'd0);
    check("ar_addr",   {27'd0, wr_addr},  32'd0);
    check("ar_data",   {24'd0, wr_data},  32'd0);
    check("ar_cursor", {27'd0, cursor},   32'd0);
    check("ar_xfer",   {16'd0, xfer_count}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check("ar_nowr",  wa_q.size(), base + 10);
    check("ar_idle",  {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
